// File: rtl/alu_resp_pkg.sv
// Shared encodings for the ALU responder: operation codes and FSM states.
// Imported by the responder top and its bench.
package alu_resp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_resp_if.sv
// Request/response handshake bundle between an operand initiator and the ALU responder.
// The initiator uses the master modport; the responder uses the slave modport.
interface alu_resp_if #(
    parameter int WIDTH = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     inA;
    logic [WIDTH-1:0]     inB;
    logic [1:0]           op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   ans;
    logic                 busy;

    modport master (
        output req_valid, inA, inB, op, rsp_ready,
        input  req_ready, rsp_valid, ans, busy
    );

    modport slave (
        input  req_valid, inA, inB, op, rsp_ready,
        output req_ready, rsp_valid, ans, busy
    );
endinterface

// File: rtl/alu_resp_mul.sv
// Iterative shift-add multiplier: one bit of B per cycle, WIDTH cycles after start.
// No backpressure; done pulses with the final product on the cycle of the last iteration.
module alu_resp_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]      cnt;
    logic               run;
    logic               last;

    assign last    = run && (cnt == CW'(WIDTH-1));
    assign partial = b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0;
    assign acc_nxt = acc + partial;

    // The final sum is handed out combinationally so the FSM can latch it on the last step.
    assign product = acc_nxt;
    assign done    = last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_resp_unit.sv
// ALU responder: accepts one operand request, computes ADD/SUB/AND in one cycle or MUL over WIDTH cycles.
// Latency 1 cycle (logic ops) or WIDTH+1 cycles (MUL) from accept to rsp_valid; optional done_cnt with ALU_RESP_CNT_EN.
// Result is held until rsp_ready; no new request is accepted until the response has been consumed.
module alu_resp_unit
    import alu_resp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_resp_if.slave        bus
`ifdef ALU_RESP_CNT_EN
    ,
    output logic [CNT_W-1:0] done_cnt
`endif
);
    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               mul_start;
    logic               ld_logic;
    logic               ld_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     a_x;
    logic [WIDTH:0]     b_x;
    logic [WIDTH:0]     logic_res;
    logic [2*WIDTH-1:0] ans_r;

    assign bus.req_ready = rst_n && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.ans       = ans_r;

    // Bit WIDTH carries the ADD carry-out or the SUB borrow.
    assign a_x = {1'b0, bus.inA};
    assign b_x = {1'b0, bus.inB};

    always_comb begin
        logic_res = '0;
        case (bus.op)
            OP_ADD:  logic_res = a_x + b_x;
            OP_SUB:  logic_res = a_x - b_x;
            OP_AND:  logic_res = a_x & b_x;
            default: logic_res = '0;
        endcase
    end

    alu_resp_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.inA),
        .b       (bus.inB),
        .product (mul_product),
        .done    (mul_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        ld_logic  = 1'b0;
        ld_mul    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        ld_logic  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    ld_mul    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ans_r <= '0;
        end else if (ld_logic) begin
            ans_r <= {{(WIDTH-1){1'b0}}, logic_res};
        end else if (ld_mul) begin
            ans_r <= mul_product;
        end
    end

`ifdef ALU_RESP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end
`else
    wire unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed bench for alu_resp_unit (WIDTH=4, CNT_W=2): table of single ops plus backpressure and reset-abort sequences.
module tb_alu_resp_unit;
    import alu_resp_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_resp_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_RESP_CNT_EN
    logic [CNT_W-1:0] done_cnt;
`endif

    alu_resp_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef ALU_RESP_CNT_EN
        ,
        .done_cnt (done_cnt)
`endif
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_ans;
        int         lat;
    } vec_t;

    vec_t             vecs [8];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_ans, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.inA       = a;
        bus.inB       = b;
        bus.op        = op;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.inA       = ~a;
        bus.inB       = ~b;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                n = i;
                break;
            end
            chk("busy_in_mul", bus.busy, 1);
        end
        chk("rsp_latency", n, lat);
        chk("ans", bus.ans, exp_ans);
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        chk("rsp_valid_drop", bus.rsp_valid, 0);
        chk("req_ready_back", bus.req_ready, 1);
`ifdef ALU_RESP_CNT_EN
        chk("done_cnt", done_cnt, exp_cnt);
`endif
    endtask

    initial begin
        vecs[0] = '{op: OP_ADD, a: 4'd1,  b: 4'd2,  exp_ans: 8'h03, lat: 1};
        vecs[1] = '{op: OP_ADD, a: 4'd15, b: 4'd15, exp_ans: 8'h1E, lat: 1};
        vecs[2] = '{op: OP_SUB, a: 4'd1,  b: 4'd4,  exp_ans: 8'h1D, lat: 1};
        vecs[3] = '{op: OP_AND, a: 4'hC,  b: 4'hA,  exp_ans: 8'h08, lat: 1};
        vecs[4] = '{op: OP_MUL, a: 4'd7,  b: 4'd6,  exp_ans: 8'h2A, lat: 5};
        vecs[5] = '{op: OP_MUL, a: 4'd15, b: 4'd15, exp_ans: 8'hE1, lat: 5};
        vecs[6] = '{op: OP_SUB, a: 4'd5,  b: 4'd3,  exp_ans: 8'h02, lat: 1};
        vecs[7] = '{op: OP_MUL, a: 4'd0,  b: 4'd9,  exp_ans: 8'h00, lat: 5};

        bus.req_valid = 1'b0;
        bus.inA       = '0;
        bus.inB       = '0;
        bus.op        = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_ans", bus.ans, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
`ifdef ALU_RESP_CNT_EN
        chk("rst_done_cnt", done_cnt, 0);
`endif
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_rst", bus.req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_ans, vecs[i].lat);
        end

        // Backpressure: result held, stray request ignored
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.inA       = 4'd3;
        bus.inB       = 4'd5;
        bus.op        = OP_ADD;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_ans", bus.ans, 8'h08);
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 1'b1;
            bus.inA       = 4'd9;
            bus.inB       = 4'd1;
            bus.op        = OP_ADD;
            @(negedge clk);
            chk("bp_hold_ans", bus.ans, 8'h08);
            chk("bp_hold_valid", bus.rsp_valid, 1);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.rsp_valid, 0);
        chk("bp_release_busy", bus.busy, 0);
        chk("bp_release_ready", bus.req_ready, 1);
`ifdef ALU_RESP_CNT_EN
        chk("bp_done_cnt", done_cnt, exp_cnt);
`endif
        @(negedge clk);
        chk("bp_no_second_rsp", bus.rsp_valid, 0);
        chk("bp_ans_kept", bus.ans, 8'h08);

        // Reset during the second MUL cycle discards the operation
        bus.req_valid = 1'b1;
        bus.inA       = 4'd7;
        bus.inB       = 4'd6;
        bus.op        = OP_MUL;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_mul1", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_ans", bus.ans, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_req_ready", bus.req_ready, 0);
        exp_cnt = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid, 0);
        end

        // Counter wrap: five completions after reset leave done_cnt at 1
        run_op(OP_ADD, 4'd1, 4'd4, 8'h05, 1);
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_ans, vecs[i].lat);
        end
`ifdef ALU_RESP_CNT_EN
        chk("done_cnt_wrap", done_cnt, 2'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
